// File: rtl/expr_vec_pkg.sv
// Shared definitions for the expression-block vector driver: operand/result
// field tables, LFSR/MISR constants and step functions, FSM state type.
package expr_vec_pkg;

  localparam int unsigned N_OPS     = 12;
  localparam int unsigned N_RES     = 18;
  localparam int unsigned AB_W      = 60;
  localparam int unsigned Y_W       = 90;
  localparam int unsigned FLD_MAX_W = 6;

  // Operand fields a0..a5,b0..b5 packed MSB-first on ab_o
  localparam int unsigned OP_WIDTH  [N_OPS] = '{4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6};
  localparam int unsigned OP_OFFSET [N_OPS] = '{56, 51, 45, 41, 36, 30, 26, 21, 15, 11, 6, 0};

  // Result fields y0..y17 packed MSB-first on y_i
  localparam int unsigned RES_WIDTH [N_RES] = '{4, 5, 6, 4, 5, 6, 4, 5, 6,
                                               4, 5, 6, 4, 5, 6, 4, 5, 6};
  localparam int unsigned RES_OFFSET[N_RES] = '{86, 81, 75, 71, 66, 60, 56, 51, 45,
                                               41, 36, 30, 26, 21, 15, 11, 6, 0};

  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? LFSR_MASK : 64'h0);
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [Y_W-1:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ f;
  endfunction

endpackage

// File: rtl/expr_y_unpack.sv
// Splits the 90-bit packed result bus into its 18 fields (zero-extended to
// 6 bits) and flags each field that is all-zero. o_fld[j] is y<j>;
// o_zero[i] refers to y<17-i> so bit order matches the packed bus.
module expr_y_unpack
  import expr_vec_pkg::*;
(
  input  logic [Y_W-1:0]       i_y,
  output logic [FLD_MAX_W-1:0] o_fld [N_RES],
  output logic [N_RES-1:0]     o_zero
);

  // Field extraction by table lookup
  always_comb begin
    o_zero = '0;
    for (int unsigned j = 0; j < N_RES; j++) begin
      o_fld[j] = FLD_MAX_W'((i_y >> RES_OFFSET[j]) & ((Y_W'(1) << RES_WIDTH[j]) - Y_W'(1)));
      o_zero[N_RES-1-j] = (o_fld[j] == '0);
    end
  end

endmodule

// File: rtl/expr_vector_driver.sv
// Vector driver for an expression block: issues LFSR operand vectors,
// compresses the LAT-delayed results into a MISR signature and offers it on
// a valid/ready port. Optional per-field toggle coverage is built when
// EXPR_DRIVER_FIELD_CHECK_EN is defined; otherwise cov_mask is tied to 0.
module expr_vector_driver
  import expr_vec_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [63:0] SEED        = 64'h1,
  parameter int unsigned LAT         = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [AB_W-1:0] ab_o,
  input  logic [Y_W-1:0]  y_i,
  output logic            busy,
  output logic            done,
  output logic [15:0]     vec_count,
  output logic            sig_valid,
  input  logic            sig_ready,
  output logic [31:0]     sig_data,
  output logic [17:0]     cov_mask
);

  localparam logic [63:0] SEED_EFF   = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [1:0]  LAT_IDX    = 2'(LAT);
  localparam logic [1:0]  DRAIN_LAST = 2'(LAT - 1);

  state_t      r_state;
  logic [63:0] r_lfsr;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_vec_count;
  logic        r_sig_valid;
  logic [31:0] r_misr;
  logic [2:0]  r_vshift;
  logic [1:0]  r_drain_cnt;

  logic        w_issue;
  logic        w_capture;
  logic        w_start_ok;
  logic [63:0] w_lfsr_next;

  assign w_issue     = (r_state == RUN);
  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_lfsr_next = lfsr_next(r_lfsr);

  // Pick the issue tag delayed by LAT cycles to mark capture cycles
  always_comb begin
    w_capture = w_issue;
    case (LAT_IDX)
      2'd0:    w_capture = w_issue;
      2'd1:    w_capture = r_vshift[0];
      2'd2:    w_capture = r_vshift[1];
      default: w_capture = r_vshift[2];
    endcase
  end

  // Run FSM with LFSR, MISR, issue tag shift register and counters.
  // r_lfsr is cleared outside a run so ab_o reads 0 in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lfsr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vec_count <= '0;
      r_sig_valid <= 1'b0;
      r_misr      <= '0;
      r_vshift    <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_done   <= 1'b0;
      r_vshift <= {r_vshift[1:0], w_issue};
      if (w_capture) begin
        r_misr <= misr_next(r_misr, y_i);
      end
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_lfsr      <= SEED_EFF;
            r_misr      <= MISR_INIT;
            r_vec_count <= '0;
          end
        end
        RUN: begin
          r_vec_count <= r_vec_count + 16'd1;
          if (r_vec_count == LAST_IDX) begin
            r_drain_cnt <= '0;
            if (LAT == 0) begin
              r_state     <= REPORT;
              r_sig_valid <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end else begin
            r_lfsr <= w_lfsr_next;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state     <= REPORT;
            r_sig_valid <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        REPORT: begin
          if (sig_ready) begin
            r_sig_valid <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_lfsr      <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ab_o      = r_lfsr[AB_W-1:0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign vec_count = r_vec_count;
  assign sig_valid = r_sig_valid;
  assign sig_data  = r_misr;

`ifdef EXPR_DRIVER_FIELD_CHECK_EN
  logic [FLD_MAX_W-1:0] w_fld [N_RES];
  logic [N_RES-1:0]     w_zero;
  logic [N_RES-1:0]     w_nz;
  logic [N_RES-1:0]     r_seen_zero;
  logic [N_RES-1:0]     r_seen_nz;

  expr_y_unpack u_unpack (
    .i_y    (y_i),
    .o_fld  (w_fld),
    .o_zero (w_zero)
  );

  // Nonzero flags in cov_mask bit order (bit i <-> y<17-i>)
  always_comb begin
    w_nz = '0;
    for (int unsigned i = 0; i < N_RES; i++) begin
      w_nz[i] = |w_fld[N_RES-1-i];
    end
  end

  // Accumulate zero / nonzero sightings per field over a run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seen_zero <= '0;
      r_seen_nz   <= '0;
    end else if (w_start_ok) begin
      r_seen_zero <= '0;
      r_seen_nz   <= '0;
    end else if (w_capture) begin
      r_seen_zero <= r_seen_zero | w_zero;
      r_seen_nz   <= r_seen_nz | w_nz;
    end
  end

  assign cov_mask = r_seen_zero & r_seen_nz;
`else
  assign cov_mask = '0;
`endif

endmodule

// File: tb/tb_expr_vector_driver.sv
// Self-checking bench for expr_vector_driver: four instances cover the fixed
// sequence, single-vector signature, back-pressure, LAT=2 equivalence with
// random results, start-while-busy, reset abort and coverage mask.
`timescale 1ns/1ps
module tb_expr_vector_driver;

  localparam int unsigned NV_L   = 37;
  localparam logic [63:0] SEED_L = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [89:0] key;

  logic        start0, ready0, busy0, done0, sv0;
  logic [59:0] ab0;
  logic [89:0] y0;
  logic [15:0] vc0;
  logic [31:0] sd0;
  logic [17:0] cm0;

  logic        start1, ready1, busy1, done1, sv1;
  logic [59:0] ab1;
  logic [89:0] y1;
  logic [15:0] vc1;
  logic [31:0] sd1;
  logic [17:0] cm1;

  logic        start2, ready2, busy2, done2, sv2;
  logic [59:0] ab2;
  logic [89:0] y2;
  logic [15:0] vc2;
  logic [31:0] sd2;
  logic [17:0] cm2;

  logic        start3, ready3, busy3, done3, sv3;
  logic [59:0] ab3;
  logic [89:0] y3, d1, d2;
  logic [15:0] vc3;
  logic [31:0] sd3;
  logic [17:0] cm3;

  // ---------------- reference model ----------------
  function automatic logic [89:0] expr_f(input logic [59:0] ab, input logic [89:0] k);
    return ({ab[29:0], ab} * 90'd3) ^ k;
  endfunction

  function automatic logic [63:0] m_step(input logic [63:0] s);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 64'hD800_0000_0000_0000;
    return n;
  endfunction

  function automatic logic [59:0] m_vec(input logic [63:0] seed, input int unsigned k);
    logic [63:0] s;
    s = (seed == 64'h0) ? 64'h1 : seed;
    for (int unsigned i = 0; i < k; i++) s = m_step(s);
    return s[59:0];
  endfunction

  // mode 0: expr_f(ab,key); 1: y=0 for ab==1 else all-ones; 2: y=0
  function automatic logic [89:0] m_y(input int mode, input logic [59:0] ab, input logic [89:0] k);
    logic [89:0] r;
    r = '0;
    if (mode == 0) r = expr_f(ab, k);
    else if (mode == 1) r = (ab == 60'h1) ? 90'h0 : {90{1'b1}};
    return r;
  endfunction

  function automatic logic [31:0] m_sig(input logic [63:0] seed, input int unsigned nv,
                                        input int mode, input logic [89:0] k);
    logic [63:0] s;
    logic [31:0] sig, f;
    logic [89:0] y;
    logic [32:0] t;
    s   = (seed == 64'h0) ? 64'h1 : seed;
    sig = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < nv; i++) begin
      y = m_y(mode, s[59:0], k);
      f = y[31:0] ^ y[63:32] ^ 32'(y[89:64]);
      t = {sig, 1'b0};
      if (t[32]) t[31:0] = t[31:0] ^ 32'h04C1_1DB7;
      sig = t[31:0] ^ f;
      s = m_step(s);
    end
    return sig;
  endfunction

  // ---------------- DUT stimulus wiring ----------------
  assign y0 = m_y(1, ab0, '0);
  assign y2 = expr_f(ab2, key);
  assign y3 = d2;

  always @(posedge clk) begin
    d1 <= expr_f(ab3, key);
    d2 <= d1;
  end

  expr_vector_driver #(.NUM_VECTORS(2), .SEED(64'h1), .LAT(0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .ab_o(ab0), .y_i(y0), .busy(busy0),
    .done(done0), .vec_count(vc0), .sig_valid(sv0), .sig_ready(ready0),
    .sig_data(sd0), .cov_mask(cm0));

  expr_vector_driver #(.NUM_VECTORS(1), .SEED(64'h0), .LAT(0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .ab_o(ab1), .y_i(y1), .busy(busy1),
    .done(done1), .vec_count(vc1), .sig_valid(sv1), .sig_ready(ready1),
    .sig_data(sd1), .cov_mask(cm1));

  expr_vector_driver #(.NUM_VECTORS(NV_L), .SEED(SEED_L), .LAT(0)) u2 (
    .clk(clk), .reset(reset), .start(start2), .ab_o(ab2), .y_i(y2), .busy(busy2),
    .done(done2), .vec_count(vc2), .sig_valid(sv2), .sig_ready(ready2),
    .sig_data(sd2), .cov_mask(cm2));

  expr_vector_driver #(.NUM_VECTORS(NV_L), .SEED(SEED_L), .LAT(2)) u3 (
    .clk(clk), .reset(reset), .start(start3), .ab_o(ab3), .y_i(y3), .busy(busy3),
    .done(done3), .vec_count(vc3), .sig_valid(sv3), .sig_ready(ready3),
    .sig_data(sd3), .cov_mask(cm3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1; ready3 = 1'b1;
    y1 = '0;
    key = '0;
    repeat (3) tick();
    n_checks++; if ({ab0, busy0, done0, vc0, sv0, sd0, cm0} !== '0)
      $display("FAIL reset_u0: got ab=%h busy=%b done=%b vc=%0d sv=%b sd=%h cov=%h expected all 0",
               ab0, busy0, done0, vc0, sv0, sd0, cm0); else n_pass++;
    n_checks++; if ({busy1, busy2, busy3, sv1, sv2, sv3} !== 6'b0)
      $display("FAIL reset_others: got busy=%b%b%b sv=%b%b%b expected 0", busy1, busy2, busy3, sv1, sv2, sv3);
    else n_pass++;
    start0 = 1'b1;
    tick();
    n_checks++; if (busy0 !== 1'b0)
      $display("FAIL start_with_reset: got busy=%b expected 0", busy0); else n_pass++;
    reset = 1'b0;
    start0 = 1'b0;
    tick();
    n_checks++; if (busy0 !== 1'b0 || ab0 !== '0)
      $display("FAIL idle_after_reset: got busy=%b ab=%h expected 0/0", busy0, ab0); else n_pass++;
  endtask

  task automatic test_vector_sequence();
    logic [17:0] exp_cov;
`ifdef EXPR_DRIVER_FIELD_CHECK_EN
    exp_cov = 18'h3FFFF;
`else
    exp_cov = 18'h0;
`endif
    start0 = 1'b1; tick(); start0 = 1'b0;
    n_checks++; if (ab0 !== 60'h1 || busy0 !== 1'b1 || vc0 !== 16'd0)
      $display("FAIL seq_vec0: got ab=%h busy=%b vc=%0d expected 1/1/0", ab0, busy0, vc0); else n_pass++;
    tick();
    n_checks++; if (ab0 !== 60'h800_0000_0000_0000 || vc0 !== 16'd1)
      $display("FAIL seq_vec1: got ab=%h vc=%0d expected 800000000000000/1", ab0, vc0); else n_pass++;
    tick();
    n_checks++; if (sv0 !== 1'b1 || sd0 !== m_sig(64'h1, 2, 1, '0))
      $display("FAIL seq_sig: got sv=%b sd=%h expected 1/%h", sv0, sd0, m_sig(64'h1, 2, 1, '0)); else n_pass++;
    tick();
    n_checks++; if (done0 !== 1'b1 || busy0 !== 1'b0 || ab0 !== '0 || vc0 !== 16'd2 || sv0 !== 1'b0)
      $display("FAIL seq_done: got done=%b busy=%b ab=%h vc=%0d sv=%b expected 1/0/0/2/0",
               done0, busy0, ab0, vc0, sv0); else n_pass++;
    n_checks++; if (cm0 !== exp_cov)
      $display("FAIL cov_mask: got %h expected %h", cm0, exp_cov); else n_pass++;
    tick();
    n_checks++; if (done0 !== 1'b0 || vc0 !== 16'd2)
      $display("FAIL seq_after: got done=%b vc=%0d expected 0/2", done0, vc0); else n_pass++;
  endtask

  task automatic test_signature_single();
    y1 = '0; ready1 = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    n_checks++; if (ab1 !== 60'h1 || busy1 !== 1'b1 || vc1 !== 16'd0)
      $display("FAIL seed0_vec: got ab=%h busy=%b vc=%0d expected 1/1/0", ab1, busy1, vc1); else n_pass++;
    tick();
    n_checks++; if (sv1 !== 1'b1 || sd1 !== 32'hFB3E_E249)
      $display("FAIL single_sig: got sv=%b sd=%h expected 1/fb3ee249", sv1, sd1); else n_pass++;
    tick();
    n_checks++; if (done1 !== 1'b1 || vc1 !== 16'd1 || sv1 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL single_done: got done=%b vc=%0d sv=%b busy=%b expected 1/1/0/0", done1, vc1, sv1, busy1);
    else n_pass++;
    tick();
    n_checks++; if (done1 !== 1'b0)
      $display("FAIL single_done_pulse: got done=%b expected 0", done1); else n_pass++;
  endtask

  task automatic test_backpressure();
    ready1 = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (sv1 !== 1'b1 || sd1 !== 32'hFB3E_E249 || done1 !== 1'b0 || busy1 !== 1'b1)
        $display("FAIL stall_hold[%0d]: got sv=%b sd=%h done=%b busy=%b expected 1/fb3ee249/0/1",
                 i, sv1, sd1, done1, busy1); else n_pass++;
      tick();
    end
    n_checks++; if (sv1 !== 1'b1 || done1 !== 1'b0)
      $display("FAIL stall_end: got sv=%b done=%b expected 1/0", sv1, done1); else n_pass++;
    ready1 = 1'b1;
    tick();
    n_checks++; if (done1 !== 1'b1 || sv1 !== 1'b0)
      $display("FAIL stall_accept: got done=%b sv=%b expected 1/0", done1, sv1); else n_pass++;
  endtask

  // LAT=0 run with random results, random ready stalls and start pulses while busy
  task automatic test_random_lat0(input logic [31:0] exp_sig);
    bit got_done = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int unsigned c = 0; c < 400 && !got_done; c++) begin
      if (c < NV_L) begin
        n_checks++; if (ab2 !== m_vec(SEED_L, c))
          $display("FAIL lat0_vec[%0d]: got %h expected %h", c, ab2, m_vec(SEED_L, c)); else n_pass++;
      end
      if (sv2) begin
        n_checks++; if (sd2 !== exp_sig)
          $display("FAIL lat0_sig: got %h expected %h", sd2, exp_sig); else n_pass++;
      end
      if (done2) begin
        got_done = 1;
        n_checks++; if (vc2 !== 16'(NV_L))
          $display("FAIL lat0_count: got %0d expected %0d", vc2, NV_L); else n_pass++;
        start2 = 1'b0;
        ready2 = 1'b1;
      end else begin
        start2 = busy2 && ($urandom_range(0, 2) == 0);
        ready2 = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    if (!got_done) begin
      n_checks++;
      $display("FAIL lat0_timeout: got no done expected done within 400 cycles");
    end
    start2 = 1'b0; ready2 = 1'b1;
    tick();
    n_checks++; if (done2 !== 1'b0 || busy2 !== 1'b0)
      $display("FAIL lat0_idle: got done=%b busy=%b expected 0/0", done2, busy2); else n_pass++;
  endtask

  // LAT=2 run with a 2-stage delayed model; ab_o must hold through drain
  task automatic test_latency(input logic [31:0] exp_sig);
    bit got_done = 0;
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int unsigned c = 0; c < 400 && !got_done; c++) begin
      if (c < NV_L + 2) begin
        n_checks++; if (ab3 !== m_vec(SEED_L, (c < NV_L) ? c : NV_L - 1))
          $display("FAIL lat2_vec[%0d]: got %h expected %h", c, ab3,
                   m_vec(SEED_L, (c < NV_L) ? c : NV_L - 1)); else n_pass++;
      end
      if (c < NV_L + 2 && sv3 !== 1'b0) begin
        n_checks++;
        $display("FAIL lat2_early_valid[%0d]: got sv=1 expected 0", c);
      end
      if (sv3) begin
        n_checks++; if (sd3 !== exp_sig)
          $display("FAIL lat2_sig: got %h expected %h", sd3, exp_sig); else n_pass++;
      end
      if (done3) begin
        got_done = 1;
        n_checks++; if (vc3 !== 16'(NV_L))
          $display("FAIL lat2_count: got %0d expected %0d", vc3, NV_L); else n_pass++;
        ready3 = 1'b1;
      end else begin
        ready3 = ($urandom_range(0, 1) == 0);
        tick();
      end
    end
    if (!got_done) begin
      n_checks++;
      $display("FAIL lat2_timeout: got no done expected done within 400 cycles");
    end
    ready3 = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    bit saw_valid = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat ($urandom_range(2, 20)) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (busy2 !== 1'b0 || ab2 !== '0 || sv2 !== 1'b0 || vc2 !== 16'd0 || done2 !== 1'b0)
      $display("FAIL abort_state: got busy=%b ab=%h sv=%b vc=%0d done=%b expected all 0",
               busy2, ab2, sv2, vc2, done2); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sv2 || done2 || busy2) saw_valid = 1;
    end
    n_checks++; if (saw_valid)
      $display("FAIL abort_no_sig: got activity after abort expected none"); else n_pass++;
  endtask

  initial begin
    logic [31:0] exp_sig;
    test_reset();
    test_vector_sequence();
    test_signature_single();
    test_backpressure();
    key = {$urandom, $urandom, $urandom};
    exp_sig = m_sig(SEED_L, NV_L, 0, key);
    test_random_lat0(exp_sig);
    test_latency(exp_sig);
    test_reset_mid_run();
    key = {$urandom, $urandom, $urandom};
    test_random_lat0(m_sig(SEED_L, NV_L, 0, key));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
